// File: rtl/conv_array_acc.sv
// conv_array_acc: KxK sliding-window convolution core with multi-channel accumulation.
// One IFM channel streams in raster order. K-1 line buffers feed a KxK window, and the
// window dot product with the latched weights is folded into an OFM-sized psum buffer.
// The last channel's totals leave on a valid/ready stream that back-pressures the input.
module conv_array_acc #(
    parameter int IFM_DATA_WIDTH = 8,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int KERNEL_SIZE    = 3,
    parameter int IFM_WIDTH      = 9,
    parameter int IFM_HEIGHT     = 9,
    parameter int NUM_CHANNEL    = 3
) (
    input  logic                                            clk1,
    input  logic                                            rst_n,
    input  logic                                            start_conv,
    input  logic                                            wgt_valid,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0] wgt_in,
    input  logic                                            ifm_valid,
    output logic                                            ifm_ready,
    input  logic [IFM_DATA_WIDTH-1:0]                       ifm_in,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [DATA_WIDTH-1:0]                           out_data,
    output logic                                            out_last,
    output logic                                            busy,
    output logic                                            done,
    output logic [$clog2(NUM_CHANNEL+1)-1:0]                channel_num
);

    localparam int K       = KERNEL_SIZE;
    localparam int OFM_W   = IFM_WIDTH - K + 1;
    localparam int OFM_H   = IFM_HEIGHT - K + 1;
    localparam int OFM_PIX = OFM_W * OFM_H;
    localparam int COL_W   = $clog2(IFM_WIDTH);
    localparam int ROW_W   = $clog2(IFM_HEIGHT);
    localparam int ADDR_W  = (OFM_PIX > 1) ? $clog2(OFM_PIX) : 1;
    localparam int CH_W    = $clog2(NUM_CHANNEL + 1);
    localparam int PROD_W  = IFM_DATA_WIDTH + WEIGHT_WIDTH;
    localparam int WGT_W   = K * K * WEIGHT_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WGT,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [COL_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [ADDR_W-1:0] oaddr;
    logic [WGT_W-1:0]  wgt_reg;

    logic adv, accept, chan_end, win_ok, first_chan, last_chan;

    logic [IFM_DATA_WIDTH-1:0] line_buf [KERNEL_SIZE-1][IFM_WIDTH];
    logic [IFM_DATA_WIDTH-1:0] win      [KERNEL_SIZE][KERNEL_SIZE];
    logic [DATA_WIDTH-1:0]     psum     [OFM_PIX];
    logic [DATA_WIDTH-1:0]     win_sum;

    logic                  vld_p0, first_p0, last_p0;
    logic [ADDR_W-1:0]     addr_p0;
    logic                  vld_p1, first_p1, last_p1;
    logic [ADDR_W-1:0]     addr_p1;
    logic [DATA_WIDTH-1:0] sum_p1;

    // All sums wrap modulo 2^DATA_WIDTH; a product is reduced before it is accumulated.
    function automatic logic [DATA_WIDTH-1:0] wrap_data(input logic [PROD_W-1:0] value);
        return DATA_WIDTH'(value);
    endfunction

    // Global advance: everything downstream of the input freezes while an output waits.
    assign adv        = !(out_valid && !out_ready);
    assign accept     = ifm_valid && ifm_ready;
    assign chan_end   = accept && (row_cnt == ROW_W'(IFM_HEIGHT - 1))
                               && (col_cnt == COL_W'(IFM_WIDTH - 1));
    assign win_ok     = (row_cnt >= ROW_W'(K - 1)) && (col_cnt >= COL_W'(K - 1));
    assign first_chan = (channel_num == '0);
    assign last_chan  = (channel_num == CH_W'(NUM_CHANNEL - 1));

    // State register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start_conv) next_state = S_LOAD_WGT;
            S_LOAD_WGT: if (wgt_valid)  next_state = S_STREAM;
            S_STREAM:   if (chan_end)   next_state = last_chan ? S_DRAIN : S_LOAD_WGT;
            S_DRAIN:    if (out_valid && out_ready && out_last) next_state = S_DONE;
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        ifm_ready = (state == S_STREAM) && adv;
    end

    // Raster position, OFM address and channel counters.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt     <= '0;
            row_cnt     <= '0;
            oaddr       <= '0;
            channel_num <= '0;
        end else if (state == S_IDLE && start_conv) begin
            col_cnt     <= '0;
            row_cnt     <= '0;
            oaddr       <= '0;
            channel_num <= '0;
        end else if (accept) begin
            if (chan_end) begin
                col_cnt <= '0;
                row_cnt <= '0;
                oaddr   <= '0;
                if (!last_chan) channel_num <= channel_num + CH_W'(1);
            end else begin
                if (col_cnt == COL_W'(IFM_WIDTH - 1)) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + ROW_W'(1);
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
                if (win_ok) oaddr <= oaddr + ADDR_W'(1);
            end
        end
    end

    // Dot product of the current window with the latched weights (MSB slice is w[0][0]).
    always_comb begin
        win_sum = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win_sum = win_sum + wrap_data(PROD_W'(win[i][j]) *
                          PROD_W'(wgt_reg[(K*K-1-(i*K+j))*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
            end
        end
    end

    // Pipeline control and output register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            first_p0  <= 1'b0;
            last_p0   <= 1'b0;
            addr_p0   <= '0;
            vld_p1    <= 1'b0;
            first_p1  <= 1'b0;
            last_p1   <= 1'b0;
            addr_p1   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            // p0: window holds a complete KxK neighbourhood of the pixel just accepted
            vld_p0    <= accept && win_ok;
            first_p0  <= first_chan;
            last_p0   <= last_chan;
            addr_p0   <= oaddr;
            // p1: window sum registered; channel tags travel with it across boundaries
            vld_p1    <= vld_p0;
            first_p1  <= first_p0;
            last_p1   <= last_p0;
            addr_p1   <= addr_p0;
            // p2: last channel presents the final total instead of writing it back
            out_valid <= vld_p1 && last_p1;
            out_last  <= vld_p1 && last_p1 && (addr_p1 == ADDR_W'(OFM_PIX - 1));
            if (vld_p1 && last_p1)
                out_data <= first_p1 ? sum_p1 : psum[addr_p1] + sum_p1;
        end
    end

    // Datapath storage: line buffers, window, weights, sum and psum buffer (never reset).
    always_ff @(posedge clk1) begin
        if (state == S_LOAD_WGT && wgt_valid) wgt_reg <= wgt_in;
        if (accept) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
            end
            for (int i = 0; i < K - 1; i++) win[i][K-1] <= line_buf[i][col_cnt];
            win[K-1][K-1] <= ifm_in;
            for (int i = 0; i < K - 2; i++) line_buf[i][col_cnt] <= line_buf[i+1][col_cnt];
            line_buf[K-2][col_cnt] <= ifm_in;
        end
        if (adv) sum_p1 <= win_sum;
        if (adv && vld_p1 && !last_p1)
            psum[addr_p1] <= first_p1 ? sum_p1 : psum[addr_p1] + sum_p1;
    end

endmodule

// File: tb/tb_conv_array_acc.sv
// tb_conv_array_acc: randomized bench for conv_array_acc against a plain-arithmetic
// convolution model. A second instance covers the K=5, 8x8, single-channel build.
module tb_conv_array_acc;

    localparam int PIX1 = 81;
    localparam int OFM1 = 49;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        start_conv, wgt_valid, ifm_valid, ifm_ready, out_valid, out_ready;
    logic [71:0] wgt_in;
    logic [7:0]  ifm_in;
    logic [15:0] out_data;
    logic        out_last, busy, done;
    logic [1:0]  channel_num;

    logic         start_b, wgt_valid_b, ifm_valid_b, ifm_ready_b, out_valid_b, out_ready_b;
    logic [199:0] wgt_in_b;
    logic [7:0]   ifm_in_b;
    logic [15:0]  out_data_b;
    logic         out_last_b, busy_b, done_b;
    logic [0:0]   channel_num_b;

    int total = 0;
    int bad   = 0;
    int ifm_m [3][9][9];
    int w_m   [3][5][5];
    int got_q [$];
    int last_q[$];
    int g_done_cnt;

    always #5 clk1 = ~clk1;

    conv_array_acc dut (
        .clk1(clk1), .rst_n(rst_n), .start_conv(start_conv), .wgt_valid(wgt_valid),
        .wgt_in(wgt_in), .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_in(ifm_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .channel_num(channel_num)
    );

    conv_array_acc #(
        .KERNEL_SIZE(5), .IFM_WIDTH(8), .IFM_HEIGHT(8), .NUM_CHANNEL(1)
    ) dut_k5 (
        .clk1(clk1), .rst_n(rst_n), .start_conv(start_b), .wgt_valid(wgt_valid_b),
        .wgt_in(wgt_in_b), .ifm_valid(ifm_valid_b), .ifm_ready(ifm_ready_b), .ifm_in(ifm_in_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_last(out_last_b), .busy(busy_b), .done(done_b), .channel_num(channel_num_b)
    );

    // Reference: OFM pixel i is the sum over channels of the KxK window dot product.
    function automatic int exp_conv(input int k, input int ow, input int nc, input int i);
        int s;
        s = 0;
        for (int ch = 0; ch < nc; ch++)
            for (int a = 0; a < k; a++)
                for (int b = 0; b < k; b++)
                    s += ifm_m[ch][i/ow + a][i%ow + b] * w_m[ch][a][b];
        return s & 32'hFFFF;
    endfunction

    function automatic logic [71:0] pack3(input int ch);
        logic [71:0] v;
        v = '0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++) v[(8 - (a*3 + b))*8 +: 8] = 8'(w_m[ch][a][b]);
        return v;
    endfunction

    function automatic logic [199:0] pack5();
        logic [199:0] v;
        v = '0;
        for (int a = 0; a < 5; a++)
            for (int b = 0; b < 5; b++) v[(24 - (a*5 + b))*8 +: 8] = 8'(w_m[0][a][b]);
        return v;
    endfunction

    // Drives one run on the default instance; stop_after >= 0 abandons it after that many accepts.
    task automatic run_main(input bit rnd_ready, input bit rnd_valid, input int stop_after);
        int idx, ch, p, first_vld_it, acc22_it, hs_last_it, done_it;
        idx = 0; first_vld_it = -1; acc22_it = -1; hs_last_it = -1; done_it = -1;
        g_done_cnt = 0;
        got_q.delete();
        last_q.delete();
        @(posedge clk1); #1;
        start_conv = 1'b1; wgt_valid = 1'b1; wgt_in = pack3(0); ifm_valid = 1'b0; out_ready = 1'b1;
        for (int it = 0; it < 3000; it++) begin
            @(posedge clk1); #1;
            out_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start_conv = 1'b0;
            if (idx < 3*PIX1) begin
                ch = idx / PIX1;
                p  = idx % PIX1;
                ifm_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
                ifm_in    = 8'(ifm_m[ch][p/9][p%9]);
                wgt_in    = (p == 0) ? pack3(ch) : 72'({$urandom(), $urandom(), $urandom()});
                if (idx > 0) start_conv = ($urandom_range(0, 3) == 0);
            end else begin
                ifm_valid = 1'b0;
                wgt_in    = 72'({$urandom(), $urandom(), $urandom()});
            end
            #1;
            if (out_valid && !out_ready) begin
                total++;
                if (ifm_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_ifm_ready: got %0b want 0 (it %0d)", ifm_ready, it);
                end
            end
            if (out_valid && first_vld_it < 0) first_vld_it = it;
            if (out_valid && out_ready) begin
                got_q.push_back(int'(out_data));
                last_q.push_back(int'(out_last));
                if (out_last) hs_last_it = it;
            end
            if (done) begin
                g_done_cnt++;
                done_it = it;
            end
            if (ifm_valid && ifm_ready) begin
                if (idx == 2*PIX1 + 2*9 + 2) acc22_it = it;
                idx++;
                if (idx == stop_after) return;
            end
            if (done_it >= 0 && it == done_it + 1) break;
        end
        ifm_valid  = 1'b0;
        start_conv = 1'b0;
        total++;
        if (got_q.size() != OFM1) begin
            bad++;
            $display("FAIL out_count: got %0d want %0d", got_q.size(), OFM1);
        end
        for (int i = 0; i < got_q.size() && i < OFM1; i++) begin
            total++;
            if (got_q[i] !== exp_conv(3, 7, 3, i)) begin
                bad++;
                $display("FAIL out_data[%0d]: got %0d want %0d", i, got_q[i], exp_conv(3, 7, 3, i));
            end
            total++;
            if (last_q[i] !== int'(i == OFM1 - 1)) begin
                bad++;
                $display("FAIL out_last[%0d]: got %0d want %0d", i, last_q[i], int'(i == OFM1 - 1));
            end
        end
        total++;
        if (g_done_cnt !== 1) begin
            bad++;
            $display("FAIL done_count: got %0d want 1", g_done_cnt);
        end
        total++;
        if (done_it !== hs_last_it + 1) begin
            bad++;
            $display("FAIL done_timing: got cycle %0d want %0d", done_it, hs_last_it + 1);
        end
        total++;
        if (first_vld_it !== acc22_it + 3) begin
            bad++;
            $display("FAIL first_out_latency: got cycle %0d want %0d", first_vld_it, acc22_it + 3);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_done: got %0b want 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_conv = 0; wgt_valid = 0; wgt_in = '0; ifm_valid = 0; ifm_in = '0; out_ready = 1;
        start_b = 0; wgt_valid_b = 0; wgt_in_b = '0; ifm_valid_b = 0; ifm_in_b = '0; out_ready_b = 1;
        repeat (3) @(posedge clk1);
        #1;
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        total++; if (out_last !== 1'b0)    begin bad++; $display("FAIL rst_out_last: got %0b want 0", out_last); end
        total++; if (out_data !== 16'd0)   begin bad++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL rst_done: got %0b want 0", done); end
        total++; if (ifm_ready !== 1'b0)   begin bad++; $display("FAIL rst_ifm_ready: got %0b want 0", ifm_ready); end
        total++; if (channel_num !== 2'd0) begin bad++; $display("FAIL rst_channel_num: got %0d want 0", channel_num); end
        total++; if (busy_b !== 1'b0)      begin bad++; $display("FAIL rst_busy_k5: got %0b want 0", busy_b); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk1);
        #1;
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL idle_busy: got %0b want 0", busy); end
    endtask

    task automatic fill_const(input int px, input int wv);
        for (int ch = 0; ch < 3; ch++) begin
            for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++) ifm_m[ch][r][c] = px;
            for (int a = 0; a < 5; a++) for (int b = 0; b < 5; b++) w_m[ch][a][b] = wv;
        end
    endtask

    task automatic test_ones();
        fill_const(1, 1);
        run_main(1'b0, 1'b0, -1);
        total++;
        if (got_q.size() > 0 && got_q[0] !== 27) begin
            bad++;
            $display("FAIL ones_value: got %0d want 27", got_q[0]);
        end
    endtask

    task automatic fill_ramp();
        for (int ch = 0; ch < 3; ch++) begin
            for (int r = 0; r < 9; r++) for (int c = 0; c < 9; c++) ifm_m[ch][r][c] = r*9 + c + ch;
            for (int a = 0; a < 5; a++) for (int b = 0; b < 5; b++) w_m[ch][a][b] = $urandom_range(0, 255);
        end
    endtask

    task automatic test_ramp();
        fill_ramp();
        run_main(1'b0, 1'b0, -1);
    endtask

    task automatic test_ramp_backpressure();
        run_main(1'b1, 1'b1, -1);
    endtask

    task automatic test_max();
        fill_const(255, 255);
        run_main(1'b0, 1'b0, -1);
        total++;
        if (got_q.size() > 0 && got_q[OFM1/2] !== 51739) begin
            bad++;
            $display("FAIL max_value: got %0d want 51739", got_q[OFM1/2]);
        end
    endtask

    task automatic test_reset_mid_run();
        fill_const(1, 1);
        run_main(1'b0, 1'b0, PIX1 + 40);
        total++;
        if (channel_num !== 2'd1) begin
            bad++;
            $display("FAIL midrun_channel: got %0d want 1", channel_num);
        end
        total++;
        if (g_done_cnt !== 0) begin
            bad++;
            $display("FAIL midrun_early_done: got %0d want 0", g_done_cnt);
        end
        @(posedge clk1); #1;
        rst_n = 1'b0; ifm_valid = 1'b0; start_conv = 1'b0;
        #2;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL midrun_rst_busy: got %0b want 0", busy); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL midrun_rst_done: got %0b want 0", done); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrun_rst_out_valid: got %0b want 0", out_valid); end
        repeat (2) @(posedge clk1);
        #1 rst_n = 1'b1;
        run_main(1'b0, 1'b0, -1);
    endtask

    task automatic test_k5_ignore();
        int idx, done_cnt;
        int got[$];
        int lst[$];
        idx = 0; done_cnt = 0;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) ifm_m[0][r][c] = $urandom_range(0, 255);
        for (int a = 0; a < 5; a++) for (int b = 0; b < 5; b++) w_m[0][a][b] = $urandom_range(0, 255);
        @(posedge clk1); #1;
        start_b = 1'b1; wgt_valid_b = 1'b1; wgt_in_b = pack5(); out_ready_b = 1'b1;
        for (int it = 0; it < 600; it++) begin
            @(posedge clk1); #1;
            start_b = 1'b0;
            if (idx < 64) begin
                ifm_valid_b = 1'b1;
                ifm_in_b    = 8'(ifm_m[0][idx/8][idx%8]);
                wgt_in_b    = (idx == 0) ? pack5() :
                              200'({$urandom(), $urandom(), $urandom(), $urandom(),
                                    $urandom(), $urandom(), $urandom()});
                if (idx > 0) start_b = ($urandom_range(0, 2) == 0);
            end else begin
                ifm_valid_b = 1'b0;
            end
            #1;
            if (out_valid_b && out_ready_b) begin
                got.push_back(int'(out_data_b));
                lst.push_back(int'(out_last_b));
            end
            if (done_b) done_cnt++;
            if (ifm_valid_b && ifm_ready_b) idx++;
            if (done_cnt > 0) break;
        end
        ifm_valid_b = 1'b0;
        start_b     = 1'b0;
        total++;
        if (got.size() != 16) begin
            bad++;
            $display("FAIL k5_out_count: got %0d want 16", got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            total++;
            if (got[i] !== exp_conv(5, 4, 1, i)) begin
                bad++;
                $display("FAIL k5_out_data[%0d]: got %0d want %0d", i, got[i], exp_conv(5, 4, 1, i));
            end
            total++;
            if (lst[i] !== int'(i == 15)) begin
                bad++;
                $display("FAIL k5_out_last[%0d]: got %0d want %0d", i, lst[i], int'(i == 15));
            end
        end
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL k5_done_count: got %0d want 1", done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_ramp();
        test_ramp_backpressure();
        test_max();
        test_reset_mid_run();
        test_k5_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
